// File: rtl/rx_block_decoder.sv
// 10GBASE-R PCS receive decoder: classifies descrambled 66-bit blocks and runs the
// receive FSM with one-block lookahead. Define RX_ERR_CNT_EN for the errored-block counter.
module rx_block_decoder #(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [65:0]          rx_block_in,
    input  logic                 rx_block_valid,
    input  logic                 block_lock,
    input  logic                 hi_ber,
    output logic [71:0]          decoder_out,
    output logic                 decoder_valid,
    output logic [2:0]           rx_state,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_cnt_clr
);

    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_C    = 3'b001,
        ST_D    = 3'b010,
        ST_T    = 3'b011,
        ST_E    = 3'b100
    } state_t;

    typedef enum logic [2:0] {BT_C, BT_S, BT_D, BT_T, BT_E} btype_t;

    localparam logic [71:0] EBLOCK = {{8{8'hFE}}, 8'hFF};
    localparam logic [71:0] LBLOCK = {8'h01, 8'h00, 8'h00, 8'h9C,
                                      8'h01, 8'h00, 8'h00, 8'h9C, 8'h11};

    function automatic logic code_legal(input logic [6:0] code);
        return (code == 7'h00) || (code == 7'h1E);
    endfunction

    function automatic logic [7:0] code_char(input logic [6:0] code);
        return (code == 7'h1E) ? 8'hFE : 8'h07;
    endfunction

    state_t      state;
    state_t      nxt_state;
    logic        stage_full;
    btype_t      stage_type;
    logic [71:0] stage_word;

    logic [7:0]  blk_type;
    logic [63:0] term_data;
    logic        is_term;
    int unsigned term_lane;
    logic        codes_ok;
    btype_t      cls_type;
    logic [71:0] cls_word;
    logic        lost;
    logic        term_ok;
    logic [71:0] emit_word;

    assign blk_type  = rx_block_in[9:2];
    // Zero-extended so the data-lane select never runs past the block.
    assign term_data = {8'h00, rx_block_in[65:10]};
    assign lost      = !block_lock || hi_ber;

    always_comb begin
        is_term   = 1'b1;
        term_lane = 0;
        case (blk_type)
            8'h87:   term_lane = 0;
            8'h99:   term_lane = 1;
            8'hAA:   term_lane = 2;
            8'hB4:   term_lane = 3;
            8'hCC:   term_lane = 4;
            8'hD2:   term_lane = 5;
            8'hE1:   term_lane = 6;
            8'hFF:   term_lane = 7;
            default: is_term   = 1'b0;
        endcase
    end

    always_comb begin
        cls_type = BT_E;
        cls_word = EBLOCK;
        codes_ok = 1'b1;
        if (rx_block_in[1:0] == 2'b01) begin
            cls_type = BT_D;
            cls_word = {rx_block_in[65:2], 8'h00};
        end else if (rx_block_in[1:0] == 2'b10) begin
            if (blk_type == 8'h1E) begin
                cls_word[7:0] = 8'hFF;
                for (int unsigned j = 0; j < 8; j++) begin
                    codes_ok &= code_legal(rx_block_in[10+7*j +: 7]);
                    cls_word[8+8*j +: 8] = code_char(rx_block_in[10+7*j +: 7]);
                end
                cls_type = codes_ok ? BT_C : BT_E;
            end else if (blk_type == 8'h78) begin
                cls_type = BT_S;
                cls_word = {rx_block_in[65:10], 8'hFB, 8'h01};
            end else if (blk_type == 8'h33) begin
                cls_word[71:40] = {rx_block_in[65:42], 8'hFB};
                cls_word[7:0]   = 8'h1F;
                for (int unsigned j = 0; j < 4; j++) begin
                    codes_ok &= code_legal(rx_block_in[10+7*j +: 7]);
                    cls_word[8+8*j +: 8] = code_char(rx_block_in[10+7*j +: 7]);
                end
                cls_type = codes_ok ? BT_S : BT_E;
            end else if (is_term) begin
                cls_word[7:0] = 8'hFF << term_lane;
                for (int unsigned j = 0; j < 8; j++) begin
                    if (j < term_lane) begin
                        cls_word[8+8*j +: 8] = term_data[8*j +: 8];
                    end else if (j == term_lane) begin
                        cls_word[8+8*j +: 8] = 8'hFD;
                    end else begin
                        codes_ok &= code_legal(rx_block_in[10+7*j +: 7]);
                        cls_word[8+8*j +: 8] = code_char(rx_block_in[10+7*j +: 7]);
                    end
                end
                cls_type = codes_ok ? BT_T : BT_E;
            end
        end
    end

    // A terminate is only accepted when the lookahead block starts or idles the link.
    assign term_ok = (stage_type == BT_T) && ((cls_type == BT_S) || (cls_type == BT_C));

    always_comb begin
        case (state)
            ST_D: begin
                if (stage_type == BT_D)  nxt_state = ST_D;
                else if (term_ok)        nxt_state = ST_T;
                else                     nxt_state = ST_E;
            end
            ST_E: begin
                if (stage_type == BT_C)      nxt_state = ST_C;
                else if (stage_type == BT_D) nxt_state = ST_D;
                else if (term_ok)            nxt_state = ST_T;
                else                         nxt_state = ST_E;
            end
            default: begin
                if (stage_type == BT_C)      nxt_state = ST_C;
                else if (stage_type == BT_S) nxt_state = ST_D;
                else                         nxt_state = ST_E;
            end
        endcase
    end

    assign emit_word = (nxt_state == ST_E) ? EBLOCK : stage_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT;
            stage_full    <= 1'b0;
            stage_type    <= BT_E;
            stage_word    <= EBLOCK;
            decoder_out   <= LBLOCK;
            decoder_valid <= 1'b0;
        end else begin
            decoder_valid <= 1'b0;
            if (lost) begin
                state      <= ST_INIT;
                stage_full <= 1'b0;
                if (rx_block_valid) begin
                    decoder_out   <= LBLOCK;
                    decoder_valid <= 1'b1;
                end
            end else if (rx_block_valid) begin
                stage_full <= 1'b1;
                stage_type <= cls_type;
                stage_word <= cls_word;
                if (stage_full) begin
                    state         <= nxt_state;
                    decoder_out   <= emit_word;
                    decoder_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_state = state;

`ifdef RX_ERR_CNT_EN
    logic eblock_emit;

    assign eblock_emit = !lost && rx_block_valid && stage_full && (nxt_state == ST_E);

    always_ff @(posedge clk) begin
        if (reset || err_cnt_clr) begin
            err_cnt <= '0;
        end else if (eblock_emit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    logic unused_err_cnt_clr;

    assign unused_err_cnt_clr = err_cnt_clr;
    assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_rx_block_decoder.sv
// Bench for rx_block_decoder: directed receive scenarios plus randomized traffic
// compared against a block-level reference model of the receive rules.
module tb_rx_block_decoder;

    localparam int unsigned W = 4;
    localparam logic [71:0] LBLK = {8'h01, 8'h00, 8'h00, 8'h9C, 8'h01, 8'h00, 8'h00, 8'h9C, 8'h11};
    localparam logic [71:0] EBLK = {{8{8'hFE}}, 8'hFF};
    localparam logic [71:0] IDLE_WORD = {{8{8'h07}}, 8'hFF};

    logic          clk = 1'b0;
    logic          reset;
    logic [65:0]   rx_block_in;
    logic          rx_block_valid;
    logic          block_lock;
    logic          hi_ber;
    logic [71:0]   decoder_out;
    logic          decoder_valid;
    logic [2:0]    rx_state;
    logic [W-1:0]  err_cnt;
    logic          err_cnt_clr;

    always #5 clk = ~clk;

    rx_block_decoder #(.ERR_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .rx_block_in(rx_block_in), .rx_block_valid(rx_block_valid),
        .block_lock(block_lock), .hi_ber(hi_ber), .decoder_out(decoder_out),
        .decoder_valid(decoder_valid), .rx_state(rx_state), .err_cnt(err_cnt),
        .err_cnt_clr(err_cnt_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: last accepted block and FSM state as 0..4.
    int          m_state;
    bit          m_full;
    logic [65:0] m_prev;
    logic [71:0] m_out;
    bit          m_vld;
    int          m_err;

    function automatic logic [65:0] ctl_blk(input logic [7:0] ty, input logic [55:0] pl);
        return {pl, ty, 2'b10};
    endfunction

    function automatic logic [65:0] dat_blk(input logic [63:0] d);
        return {d, 2'b01};
    endfunction

    function automatic bit ref_code(input logic [6:0] code, output logic [7:0] ch);
        ch = (code == 7'h1E) ? 8'hFE : 8'h07;
        return (code == 7'h00) || (code == 7'h1E);
    endfunction

    function automatic void ref_decode(input logic [65:0] b, output logic [7:0] kind,
                                       output logic [71:0] w);
        logic [7:0]  lane [8];
        logic [7:0]  tcodes [8];
        logic [63:0] tdat;
        logic [7:0]  ctl;
        logic [7:0]  ch;
        int          tk;
        bit          ok;
        tcodes = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        tdat   = {8'h00, b[65:10]};
        kind   = "E";
        ok     = 1'b1;
        ctl    = 8'h00;
        tk     = -1;
        for (int i = 0; i < 8; i++) lane[i] = b[2+8*i +: 8];
        if (b[1:0] == 2'b01) begin
            kind = "D";
        end else if (b[1:0] == 2'b10) begin
            for (int i = 0; i < 8; i++) if (tcodes[i] == b[9:2]) tk = i;
            if (b[9:2] == 8'h1E) begin
                ctl = 8'hFF;
                for (int i = 0; i < 8; i++) begin ok &= ref_code(b[10+7*i +: 7], ch); lane[i] = ch; end
                if (ok) kind = "C";
            end else if (b[9:2] == 8'h78) begin
                ctl = 8'h01; lane[0] = 8'hFB; kind = "S";
            end else if (b[9:2] == 8'h33) begin
                ctl = 8'h1F; lane[4] = 8'hFB;
                for (int i = 0; i < 4; i++) begin ok &= ref_code(b[10+7*i +: 7], ch); lane[i] = ch; end
                if (ok) kind = "S";
            end else if (tk >= 0) begin
                ctl = 8'hFF << tk;
                for (int i = 0; i < 8; i++) begin
                    if (i < tk) lane[i] = tdat[8*i +: 8];
                    else if (i == tk) lane[i] = 8'hFD;
                    else begin ok &= ref_code(b[10+7*i +: 7], ch); lane[i] = ch; end
                end
                if (ok) kind = "T";
            end
        end
        w[7:0] = ctl;
        for (int i = 0; i < 8; i++) w[8+8*i +: 8] = lane[i];
    endfunction

    function automatic int ref_next(input int st, input logic [7:0] r, input logic [7:0] nx);
        bit t_ok;
        t_ok = (r == "T") && (nx == "S" || nx == "C");
        if (st == 2) return (r == "D") ? 2 : (t_ok ? 3 : 4);
        if (st == 4) return (r == "C") ? 1 : (r == "D") ? 2 : (t_ok ? 3 : 4);
        return (r == "C") ? 1 : (r == "S") ? 2 : 4;
    endfunction

    function automatic logic [6:0] rand_code();
        int p;
        p = $urandom_range(0, 19);
        if (p < 14) return 7'h00;
        if (p < 18) return 7'h1E;
        return 7'($urandom);
    endfunction

    function automatic logic [65:0] rand_blk();
        logic [63:0] r64;
        logic [55:0] pl;
        logic [7:0]  tcodes [8];
        logic [65:0] blk;
        int          k;
        tcodes = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        r64 = {$urandom, $urandom};
        pl  = r64[55:0];
        case ($urandom_range(0, 11))
            0, 1: begin
                for (int j = 0; j < 8; j++) pl[7*j +: 7] = rand_code();
                blk = ctl_blk(8'h1E, pl);
            end
            2: blk = ctl_blk(8'h78, pl);
            3: begin
                for (int j = 0; j < 4; j++) pl[7*j +: 7] = rand_code();
                blk = ctl_blk(8'h33, pl);
            end
            4, 5, 6: blk = dat_blk(r64);
            7, 8, 9: begin
                k = $urandom_range(0, 7);
                for (int j = k + 1; j < 8; j++) pl[7*j +: 7] = rand_code();
                blk = ctl_blk(tcodes[k], pl);
            end
            10: blk = {r64, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11};
            default: blk = ctl_blk(8'($urandom), pl);
        endcase
        return blk;
    endfunction

    // Drive one cycle at a negedge, advance the model, and wait for the outputs.
    task automatic cycle(input logic [65:0] blk, input bit vld, input bit clr);
        logic [7:0]  r, nx;
        logic [71:0] w, unused_w;
        bit          eblk;
        rx_block_in = blk; rx_block_valid = vld; err_cnt_clr = clr;
        eblk  = 1'b0;
        m_vld = 1'b0;
        if (!block_lock || hi_ber) begin
            m_state = 0; m_full = 1'b0;
            if (vld) begin m_vld = 1'b1; m_out = LBLK; end
        end else if (vld) begin
            if (m_full) begin
                ref_decode(m_prev, r, w);
                ref_decode(blk, nx, unused_w);
                m_state = ref_next(m_state, r, nx);
                m_vld   = 1'b1;
                eblk    = (m_state == 4);
                m_out   = eblk ? EBLK : w;
            end
            m_prev = blk; m_full = 1'b1;
        end
`ifdef RX_ERR_CNT_EN
        if (clr) m_err = 0;
        else if (eblk && m_err < (1 << W) - 1) m_err++;
`else
        m_err = 0;
`endif
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0; m_full = 1'b0; m_out = LBLK; m_vld = 1'b0; m_err = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; block_lock = 1'b1; hi_ber = 1'b0; err_cnt_clr = 1'b0;
        rx_block_valid = 1'b1; rx_block_in = ctl_blk(8'h1E, 56'h0);
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (decoder_out !== LBLK) begin n_fail++; $display("FAIL reset_out: got %h want %h", decoder_out, LBLK); end
        n_checks++;
        if (decoder_valid !== 1'b0 || rx_state !== 3'b000) begin
            n_fail++; $display("FAIL reset_vld_state: got valid=%0b state=%0d want 0/0", decoder_valid, rx_state);
        end
        n_checks++;
        if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        reset = 1'b0; rx_block_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        int outs;
        outs = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
            if (decoder_valid === 1'b1) outs++;
            n_checks++;
            if (decoder_valid !== m_vld || rx_state !== 3'(m_state) || (m_vld && decoder_out !== m_out)) begin
                n_fail++;
                $display("FAIL idle_step%0d: got v=%0b st=%0d out=%h want v=%0b st=%0d out=%h",
                         i, decoder_valid, rx_state, decoder_out, m_vld, m_state, m_out);
            end
        end
        n_checks++;
        if (outs !== 9 || decoder_out !== IDLE_WORD || rx_state !== 3'd1) begin
            n_fail++;
            $display("FAIL idle_summary: got outs=%0d out=%h st=%0d want 9 %h 1", outs, decoder_out, rx_state, IDLE_WORD);
        end
        cycle(66'h0, 1'b0, 1'b0);
    endtask

    task automatic test_packet();
        logic [63:0] d;
        d = {$urandom, $urandom};
        cycle(ctl_blk(8'h78, 56'h77665544332211), 1'b1, 1'b0);
        cycle(dat_blk(d), 1'b1, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b1 || decoder_out !== 72'h77665544332211FB01 || rx_state !== 3'd2) begin
            n_fail++; $display("FAIL pkt_start: got v=%0b out=%h st=%0d", decoder_valid, decoder_out, rx_state);
        end
        cycle(ctl_blk(8'hB4, 56'hCCBBAA), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== {d, 8'h00} || rx_state !== 3'd2) begin
            n_fail++; $display("FAIL pkt_data: got out=%h st=%0d want %h 2", decoder_out, rx_state, {d, 8'h00});
        end
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== 72'h07070707FDCCBBAAF8 || rx_state !== 3'd3 || decoder_out !== m_out) begin
            n_fail++; $display("FAIL pkt_term: got out=%h st=%0d want 07070707FDCCBBAAF8 3", decoder_out, rx_state);
        end
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== IDLE_WORD || rx_state !== 3'd1) begin
            n_fail++; $display("FAIL pkt_idle: got out=%h st=%0d want %h 1", decoder_out, rx_state, IDLE_WORD);
        end
    endtask

    task automatic test_bad_term();
        cycle(ctl_blk(8'h78, 56'h0), 1'b1, 1'b0);
        cycle(dat_blk(64'h0123456789ABCDEF), 1'b1, 1'b0);
        cycle(ctl_blk(8'h87, 56'h0), 1'b1, 1'b0);
        cycle(dat_blk(64'hFEDCBA9876543210), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== EBLK || rx_state !== 3'd4) begin
            n_fail++; $display("FAIL bad_term: got out=%h st=%0d want %h 4", decoder_out, rx_state, EBLK);
        end
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== {64'hFEDCBA9876543210, 8'h00} || rx_state !== 3'd2) begin
            n_fail++; $display("FAIL bad_term_recover: got out=%h st=%0d want data 2", decoder_out, rx_state);
        end
    endtask

    task automatic test_bad_sync();
        logic [63:0] d;
        d = {$urandom, $urandom};
        cycle(ctl_blk(8'h33, 56'h0), 1'b1, 1'b0);
        cycle(dat_blk(64'h1111), 1'b1, 1'b0);
        cycle({64'h5555AAAA5555AAAA, 2'b11}, 1'b1, 1'b0);
        cycle(dat_blk(d), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== EBLK || rx_state !== 3'd4) begin
            n_fail++; $display("FAIL bad_sync: got out=%h st=%0d want %h 4", decoder_out, rx_state, EBLK);
        end
        cycle(ctl_blk(8'hFF, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b1 || decoder_out !== {d, 8'h00} || rx_state !== 3'd2) begin
            n_fail++; $display("FAIL bad_sync_e2d: got out=%h st=%0d want %h 2", decoder_out, rx_state, {d, 8'h00});
        end
    endtask

    task automatic test_back_to_back();
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        cycle(ctl_blk(8'h78, 56'h0), 1'b1, 1'b0);
        cycle(ctl_blk(8'hD2, 56'h0), 1'b1, 1'b0);
        cycle(ctl_blk(8'h78, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (rx_state !== 3'd3 || decoder_out !== m_out || decoder_out[7:0] !== 8'hE0) begin
            n_fail++; $display("FAIL b2b_term: got out=%h st=%0d want %h 3", decoder_out, rx_state, m_out);
        end
        cycle(ctl_blk(8'h99, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (rx_state !== 3'd2 || decoder_out !== 72'h0000000000000000FB01) begin
            n_fail++; $display("FAIL b2b_start: got out=%h st=%0d want start 2", decoder_out, rx_state);
        end
    endtask

    task automatic test_lock_loss();
        block_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(rand_blk(), 1'b1, 1'b0);
            n_checks++;
            if (decoder_valid !== 1'b1 || decoder_out !== LBLK || rx_state !== 3'd0) begin
                n_fail++; $display("FAIL lock_loss%0d: got v=%0b out=%h st=%0d want 1 %h 0", i, decoder_valid, decoder_out, rx_state, LBLK);
            end
        end
        cycle(66'h0, 1'b0, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b0) begin n_fail++; $display("FAIL lock_loss_idle: got valid=%0b want 0", decoder_valid); end
        block_lock = 1'b1; hi_ber = 1'b1;
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b1 || decoder_out !== LBLK) begin
            n_fail++; $display("FAIL hi_ber: got v=%0b out=%h want 1 %h", decoder_valid, decoder_out, LBLK);
        end
        hi_ber = 1'b0;
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b0 || rx_state !== 3'd0) begin
            n_fail++; $display("FAIL relock_first: got v=%0b st=%0d want 0 0", decoder_valid, rx_state);
        end
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b1 || decoder_out !== IDLE_WORD || rx_state !== 3'd1) begin
            n_fail++; $display("FAIL relock_second: got v=%0b out=%h st=%0d", decoder_valid, decoder_out, rx_state);
        end
    endtask

    task automatic test_reset_mid_packet();
        cycle(ctl_blk(8'h78, 56'h0), 1'b1, 1'b0);
        cycle(dat_blk(64'h42), 1'b1, 1'b0);
        reset = 1'b1; rx_block_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_valid !== 1'b0 || rx_state !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid_first: got v=%0b st=%0d want 0 0", decoder_valid, rx_state);
        end
        cycle(ctl_blk(8'h1E, 56'h0), 1'b1, 1'b0);
        n_checks++;
        if (decoder_out !== IDLE_WORD || rx_state !== 3'd1) begin
            n_fail++; $display("FAIL rst_mid_second: got out=%h st=%0d want idle 1", decoder_out, rx_state);
        end
    endtask

    task automatic test_err_cnt();
        for (int i = 0; i < 3; i++) cycle(ctl_blk(8'h1E, 56'h0), 1'b1, (i == 2));
        for (int i = 0; i < 6; i++) cycle({64'hDEAD, 2'b00}, 1'b1, 1'b0);
`ifdef RX_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== W'(5) || err_cnt !== W'(m_err)) begin
            n_fail++; $display("FAIL err_cnt_five: got %0d want 5", err_cnt);
        end
        cycle({64'hBEEF, 2'b11}, 1'b1, 1'b1);
        n_checks++;
        if (decoder_out !== EBLK || err_cnt !== '0) begin
            n_fail++; $display("FAIL err_cnt_clr: got cnt=%0d out=%h want 0 %h", err_cnt, decoder_out, EBLK);
        end
        for (int i = 0; i < 20; i++) cycle({64'hBEEF, 2'b11}, 1'b1, 1'b0);
        n_checks++;
        if (err_cnt !== '1) begin n_fail++; $display("FAIL err_cnt_sat: got %0d want %0d", err_cnt, (1 << W) - 1); end
`else
        n_checks++;
        if (err_cnt !== '0) begin n_fail++; $display("FAIL err_cnt_tied: got %0d want 0", err_cnt); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            block_lock = ($urandom_range(0, 39) != 0);
            hi_ber     = ($urandom_range(0, 59) == 0);
            cycle(rand_blk(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 39) == 0));
            n_checks++;
            if (decoder_valid !== m_vld || rx_state !== 3'(m_state)) begin
                n_fail++; $display("FAIL rand_ctl%0d: got v=%0b st=%0d want v=%0b st=%0d", i, decoder_valid, rx_state, m_vld, m_state);
            end
            if (m_vld) begin
                n_checks++;
                if (decoder_out !== m_out) begin
                    n_fail++; $display("FAIL rand_out%0d: got %h want %h", i, decoder_out, m_out);
                end
            end
            n_checks++;
            if (err_cnt !== W'(m_err)) begin
                n_fail++; $display("FAIL rand_err%0d: got %0d want %0d", i, err_cnt, m_err);
            end
        end
        block_lock = 1'b1; hi_ber = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_block_in = '0; rx_block_valid = 1'b0;
        block_lock = 1'b1; hi_ber = 1'b0; err_cnt_clr = 1'b0;
        model_reset();
        m_prev = '0;
        test_reset();
        test_idle();
        test_packet();
        test_bad_term();
        test_bad_sync();
        test_back_to_back();
        test_lock_loss();
        test_reset_mid_packet();
        test_err_cnt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
